// File: rtl/uart_rx_packet.sv
// Packet UART receiver: reassembles NUM_BYTES back-to-back framed bytes
// (start 0, 8 data bits MSB-first, stop 1) into one parallel packet.
module uart_rx_packet #(
  parameter int BIT_PERIOD = 8,
  parameter int NUM_BYTES  = 36
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   serial_in,
  output logic [NUM_BYTES*8-1:0] rx_data,
  output logic                   data_ready,
  output logic                   framing_error,
  output logic                   busy
);

  localparam int TW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(BIT_PERIOD / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t                 state;
  logic                   s_meta;
  logic                   s_in;
  logic                   s_prev;
  logic                   fall;
  logic [TW-1:0]          timer;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic [CW-1:0]          byte_cnt;
  logic [NUM_BYTES*8-1:0] asm_reg;

  // Synchronizer and edge-detect flops idle high, matching the line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_meta <= 1'b1;
      s_in   <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= serial_in;
      s_in   <= s_meta;
      s_prev <= s_in;
    end
  end

  assign fall = s_prev & ~s_in;
  assign busy = (byte_cnt != '0) || (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_cnt      <= '0;
      asm_reg       <= '0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            timer         <= '0;
            framing_error <= 1'b0;
            state         <= START;
          end
        end

        START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (s_in) begin
              state <= IDLE;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            shreg <= {shreg[6:0], s_in};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (s_in) begin
              // Constant-index unroll of the byte_cnt-addressed slot; byte 0 is the top byte.
              for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (byte_cnt == CW'(i)) begin
                  asm_reg[(NUM_BYTES - i) * 8 - 1 -: 8] <= shreg;
                end
              end
              if (byte_cnt == LAST_BYTE) begin
                state <= DONE;
              end else begin
                byte_cnt <= byte_cnt + CW'(1);
                state    <= IDLE;
              end
            end else begin
              framing_error <= 1'b1;
              byte_cnt      <= '0;
              state         <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DONE: begin
          rx_data    <= asm_reg;
          data_ready <= 1'b1;
          byte_cnt   <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_packet.sv
// Scoreboard bench for uart_rx_packet: stimulus pushes expected packets,
// a negedge monitor pops and compares on every data_ready pulse.
module tb_uart_rx_packet;

  localparam int BP = 8;
  localparam int NB = 36;
  localparam int W  = NB * 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         serial_in = 1'b1;
  logic [W-1:0] rx_data;
  logic         data_ready;
  logic         framing_error;
  logic         busy;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           pulses = 0;
  int           last_pulse_cyc = 0;
  logic [W-1:0] exp_q[$];

  uart_rx_packet #(.BIT_PERIOD(BP), .NUM_BYTES(NB)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests = tests + 1;
    if (act < lo || act > hi) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: each pulse must match the oldest expected packet.
  always @(negedge clk) begin
    if (n_rst && data_ready) begin
      pulses = pulses + 1;
      last_pulse_cyc = cyc;
      tests = tests + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_pulse: got rx_data %h expected no pulse", rx_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e || framing_error !== 1'b0) begin
          fails = fails + 1;
          $display("FAIL packet: got %h fe=%b expected %h fe=0", rx_data, framing_error, e);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    serial_in = v;
    repeat (BP) wait_clk();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) wait_clk();
  endtask

  logic [W-1:0] pkt;
  logic [W-1:0] prev_pkt;
  int           t_start;
  int           p0;

  initial begin
    // Reset state
    repeat (3) wait_clk();
    check_val("reset_rx_data", rx_data, '0);
    check_val("reset_ready", W'(data_ready), '0);
    check_val("reset_fe", W'(framing_error), '0);
    check_val("reset_busy", W'(busy), '0);
    n_rst = 1'b1;

    // Idle line
    idle(1000);
    check_range("idle_pulses", pulses, 0, 0);
    check_val("idle_busy", W'(busy), '0);
    check_val("idle_rx_data", rx_data, '0);

    // Counting packet 0x00..0x23, with latency from the first falling edge
    pkt = '0;
    for (int i = 0; i < NB; i++) pkt = {pkt[W-9:0], 8'(i)};
    check_val("count_top_byte", W'(pkt[W-1 -: 8]), W'(8'h00));
    check_val("count_low_byte", W'(pkt[7:0]), W'(8'h23));
    exp_q.push_back(pkt);
    p0 = pulses;
    t_start = cyc;
    for (int i = 0; i < NB; i++) send_frame(8'(i), 1'b1);
    idle(10);
    check_range("count_pulses", pulses - p0, 1, 1);
    check_range("count_latency", last_pulse_cyc - t_start, 3 + NB * 10 * BP - 4, 3 + NB * 10 * BP - 2);
    check_val("count_fe", W'(framing_error), '0);
    check_val("count_busy", W'(busy), '0);
    prev_pkt = pkt;

    // 3-clock glitch: START sampling rejects it
    serial_in = 1'b0;
    repeat (3) wait_clk();
    serial_in = 1'b1;
    repeat (2) wait_clk();
    check_val("glitch_busy_in_start", W'(busy), W'(1'b1));
    idle(20);
    check_val("glitch_busy", W'(busy), '0);
    check_val("glitch_fe", W'(framing_error), '0);
    check_val("glitch_rx_data", rx_data, prev_pkt);

    // Framing error on byte 5, then a good packet clears it
    p0 = pulses;
    for (int i = 0; i < 5; i++) send_frame(8'hC0 + 8'(i), 1'b1);
    check_val("fe_busy_partial", W'(busy), W'(1'b1));
    send_frame(8'h55, 1'b0);
    idle(20);
    check_val("fe_set", W'(framing_error), W'(1'b1));
    check_val("fe_busy", W'(busy), '0);
    check_val("fe_rx_kept", rx_data, prev_pkt);
    pkt = '0;
    for (int i = 0; i < NB; i++) pkt = {pkt[W-9:0], 8'(i * 7 + 3)};
    exp_q.push_back(pkt);
    send_frame(8'(3), 1'b1);
    check_val("fe_cleared", W'(framing_error), '0);
    for (int i = 1; i < NB; i++) send_frame(8'(i * 7 + 3), 1'b1);
    idle(20);
    check_range("fe_recover_pulses", pulses - p0, 1, 1);

    // Two packets with random inter-frame gaps
    p0 = pulses;
    exp_q.push_back({NB{8'hA5}});
    exp_q.push_back({NB{8'h3C}});
    for (int i = 0; i < NB; i++) begin
      send_frame(8'hA5, 1'b1);
      idle(int'($urandom_range(50, 0)));
    end
    check_val("gap_rx_a5", rx_data, {NB{8'hA5}});
    for (int i = 0; i < NB; i++) begin
      send_frame(8'h3C, 1'b1);
      idle(int'($urandom_range(50, 0)));
    end
    idle(20);
    check_range("gap_pulses", pulses - p0, 2, 2);
    check_val("gap_rx_3c", rx_data, {NB{8'h3C}});

    // Reset during byte 20, then a clean packet
    p0 = pulses;
    for (int i = 0; i < 20; i++) send_frame(8'hFF, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    n_rst = 1'b0;
    #1;
    check_val("rst_mid_rx_data", rx_data, '0);
    check_val("rst_mid_busy", W'(busy), '0);
    check_val("rst_mid_fe", W'(framing_error), '0);
    check_val("rst_mid_ready", W'(data_ready), '0);
    serial_in = 1'b1;
    repeat (2) wait_clk();
    n_rst = 1'b1;
    idle(20);
    pkt = '0;
    for (int i = 0; i < NB; i++) pkt = {pkt[W-9:0], 8'hF0 ^ 8'(i)};
    exp_q.push_back(pkt);
    for (int i = 0; i < NB; i++) send_frame(8'hF0 ^ 8'(i), 1'b1);
    idle(20);
    check_range("post_rst_pulses", pulses - p0, 1, 1);
    check_val("post_rst_rx", rx_data, pkt);

    check_range("scoreboard_empty", exp_q.size(), 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
